// File: rtl/uart_partner.sv
// rtl/uart_partner.sv - full-duplex UART with TX/RX FIFOs, configurable framing and sticky error flags
module uart_partner #(
  parameter int clk_freq       = 100000000,
  parameter int uart_baud_rate = 1152000,
  parameter int data_bits      = 8,
  parameter int parity         = 0,
  parameter int stop_bits      = 1,
  parameter int fifo_depth     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [data_bits-1:0]          tx_data,
  input  logic                          tx_wr,
  output logic                          tx_full,
  output logic                          tx_empty,
  output logic                          tx_busy,
  output logic [data_bits-1:0]          rx_data,
  input  logic                          rx_rd,
  output logic                          rx_empty,
  output logic [$clog2(fifo_depth):0]   rx_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  input  logic                          uart_rxd,
  output logic                          uart_txd
);
  localparam int DIV_RAW = (clk_freq + uart_baud_rate / 2) / uart_baud_rate;
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int AW      = $clog2(fifo_depth);
  localparam int CW      = $clog2(2 * DIV + 1);
  localparam bit HAS_PAR = (parity != 0);
  localparam bit ODD     = (parity == 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(stop_bits * DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(data_bits - 1);
  localparam logic [AW:0]   DEPTH_C   = fifo_depth[AW:0];

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [data_bits-1:0] r_tx_mem [fifo_depth];
  logic [AW-1:0]        r_tx_wp, r_tx_rp;
  logic [AW:0]          r_tx_cnt;
  logic                 w_tx_push, w_tx_pop, w_tx_tick, w_tx_par;
  logic [data_bits-1:0] w_tx_head;
  state_t               r_tx_state, w_tx_next;
  logic [CW-1:0]        r_tx_tcnt;
  logic [2:0]           r_tx_bit;
  logic [data_bits:0]   r_tx_shift;
  logic                 r_txd, r_tx_busy;

  assign tx_full   = (r_tx_cnt == DEPTH_C);
  assign tx_empty  = (r_tx_cnt == '0);
  assign w_tx_push = tx_wr & ~tx_full;
  assign w_tx_head = r_tx_mem[r_tx_rp];
  assign w_tx_par  = (^w_tx_head) ^ ODD;
  assign w_tx_tick = (r_tx_tcnt == ((r_tx_state == S_STOP) ? STOP_LAST : BIT_LAST));
  assign uart_txd  = r_txd;
  assign tx_busy   = r_tx_busy;

  always_ff @(posedge clk) if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  // STOP chains straight into the next START when another character is queued
  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      S_IDLE:   if (!tx_empty) begin w_tx_next = S_START; w_tx_pop = 1'b1; end
      S_START:  if (w_tx_tick) w_tx_next = S_DATA;
      S_DATA:   if (w_tx_tick && r_tx_bit == LAST_BIT) w_tx_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (w_tx_tick) w_tx_next = S_STOP;
      S_STOP:   if (w_tx_tick) begin
                  if (!tx_empty) begin w_tx_next = S_START; w_tx_pop = 1'b1; end
                  else w_tx_next = S_IDLE;
                end
      default:  w_tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= S_IDLE; r_tx_tcnt <= '0; r_tx_bit <= '0;
      r_tx_shift <= '0; r_txd <= 1'b1; r_tx_busy <= 1'b0;
    end else begin
      r_tx_state <= w_tx_next;
      r_tx_tcnt  <= (r_tx_state == S_IDLE || w_tx_tick) ? '0 : r_tx_tcnt + 1'b1;
      if (w_tx_pop) r_tx_shift <= {w_tx_par, w_tx_head};
      else if (r_tx_state == S_DATA && w_tx_tick) r_tx_shift <= {1'b1, r_tx_shift[data_bits:1]};
      if (r_tx_state != S_DATA) r_tx_bit <= '0;
      else if (w_tx_tick) r_tx_bit <= r_tx_bit + 1'b1;
      r_txd     <= (r_tx_state == S_START) ? 1'b0 :
                   (r_tx_state == S_DATA || r_tx_state == S_PARITY) ? r_tx_shift[0] : 1'b1;
      r_tx_busy <= (r_tx_state != S_IDLE);
    end
  end

  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  state_t               r_rx_state, w_rx_next;
  logic [CW-1:0]        r_rx_tcnt;
  logic [2:0]           r_rx_bit;
  logic [data_bits-1:0] r_rx_shift;
  logic                 r_rx_par;
  logic                 w_rx_fall, w_rx_tick, w_rx_done, w_rx_par_ok, w_rx_good;
  logic [data_bits-1:0] r_rx_mem [fifo_depth];
  logic [AW-1:0]        r_rx_wp, r_rx_rp;
  logic [AW:0]          r_rx_cnt;
  logic                 w_rx_full, w_rx_push, w_rx_pop, w_rx_ovr;
  logic                 r_perr, r_ferr, r_ovr;

  assign w_rx_fall   = r_rx_prev & ~r_rx_s2;
  assign w_rx_tick   = (r_rx_tcnt == ((r_rx_state == S_START) ? HALF_LAST : BIT_LAST));
  assign w_rx_par_ok = !HAS_PAR || (r_rx_par == ((^r_rx_shift) ^ ODD));
  assign w_rx_good   = w_rx_done & r_rx_s2 & w_rx_par_ok;

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_done = 1'b0;
    case (r_rx_state)
      S_IDLE:   if (w_rx_fall) w_rx_next = S_START;
      S_START:  if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:   if (w_rx_tick && r_rx_bit == LAST_BIT) w_rx_next = HAS_PAR ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_tick) w_rx_next = S_STOP;
      S_STOP:   if (w_rx_tick) begin w_rx_next = S_IDLE; w_rx_done = 1'b1; end
      default:  w_rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1; r_rx_s2 <= 1'b1; r_rx_prev <= 1'b1;
      r_rx_state <= S_IDLE; r_rx_tcnt <= '0; r_rx_bit <= '0;
      r_rx_shift <= '0; r_rx_par <= 1'b0;
    end else begin
      r_rx_s1    <= uart_rxd;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_next;
      r_rx_tcnt  <= (r_rx_state == S_IDLE || w_rx_tick) ? '0 : r_rx_tcnt + 1'b1;
      if (r_rx_state != S_DATA) r_rx_bit <= '0;
      else if (w_rx_tick) begin
        r_rx_bit   <= r_rx_bit + 1'b1;
        r_rx_shift <= {r_rx_s2, r_rx_shift[data_bits-1:1]};
      end
      if (r_rx_state == S_PARITY && w_rx_tick) r_rx_par <= r_rx_s2;
    end
  end

  // A same-cycle pop frees the slot, so a full FIFO only overruns without one
  assign w_rx_full = (r_rx_cnt == DEPTH_C);
  assign rx_empty  = (r_rx_cnt == '0);
  assign w_rx_pop  = rx_rd & ~rx_empty;
  assign w_rx_push = w_rx_good & (~w_rx_full | w_rx_pop);
  assign w_rx_ovr  = w_rx_good & w_rx_full & ~w_rx_pop;
  assign rx_data   = rx_empty ? '0 : r_rx_mem[r_rx_rp];
  assign rx_count  = r_rx_cnt;

  always_ff @(posedge clk) if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
      r_perr <= 1'b0; r_ferr <= 1'b0; r_ovr <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
      r_perr <= (r_perr & ~err_clr) | (w_rx_done & r_rx_s2 & ~w_rx_par_ok);
      r_ferr <= (r_ferr & ~err_clr) | (w_rx_done & ~r_rx_s2);
      r_ovr  <= (r_ovr  & ~err_clr) | w_rx_ovr;
    end
  end

  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
endmodule

// File: tb/tb_uart_partner.sv
// tb/tb_uart_partner.sv - randomized self-checking bench for uart_partner (8N1 default and 7E2 depth-4 instances)
module tb_uart_partner;
  localparam int DIV0 = 87;
  localparam int DIV1 = 10;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] tx_data0, rx_data0;
  logic tx_wr0, tx_full0, tx_empty0, tx_busy0, rx_rd0, rx_empty0;
  logic [4:0] rx_count0;
  logic pe0, fe0, ov0, err_clr0, rxd0, txd0, drv0, lb0;
  logic [6:0] tx_data1, rx_data1;
  logic tx_wr1, tx_full1, tx_empty1, tx_busy1, rx_rd1, rx_empty1;
  logic [2:0] rx_count1;
  logic pe1, fe1, ov1, err_clr1, txd1, drv1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  assign rxd0 = lb0 ? txd0 : drv0;

  uart_partner u0 (
    .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_full(tx_full0),
    .tx_empty(tx_empty0), .tx_busy(tx_busy0), .rx_data(rx_data0), .rx_rd(rx_rd0),
    .rx_empty(rx_empty0), .rx_count(rx_count0), .parity_err(pe0), .frame_err(fe0),
    .overrun(ov0), .err_clr(err_clr0), .uart_rxd(rxd0), .uart_txd(txd0)
  );

  uart_partner #(
    .clk_freq(100000000), .uart_baud_rate(10000000), .data_bits(7),
    .parity(2), .stop_bits(2), .fifo_depth(4)
  ) u1 (
    .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_full(tx_full1),
    .tx_empty(tx_empty1), .tx_busy(tx_busy1), .rx_data(rx_data1), .rx_rd(rx_rd1),
    .rx_empty(rx_empty1), .rx_count(rx_count1), .parity_err(pe1), .frame_err(fe1),
    .overrun(ov1), .err_clr(err_clr1), .uart_rxd(drv1), .uart_txd(txd1)
  );

  // Drives one serial frame on a DUT's RX line from the framing rules; rd_at pulses rx_rd1 at that clock offset
  task automatic send_frame(input int which, input logic [7:0] dv, input bit flip_par,
                            input bit stop_val, input int rd_at);
    int div, nb, nt;
    logic p;
    logic [11:0] fb;
    div = which ? DIV1 : DIV0;
    nb  = which ? 7 : 8;
    p = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ dv[i];
    if (flip_par) p = ~p;
    fb = '0;
    for (int i = 0; i < nb; i++) fb[1+i] = dv[i];
    nt = 1 + nb;
    if (which != 0) begin fb[nt] = p; nt++; end
    fb[nt] = stop_val;
    nt++;
    for (int b = 0; b < nt; b++)
      for (int c = 0; c < div; c++) begin
        if (which != 0) begin drv1 = fb[b]; rx_rd1 = (b * div + c == rd_at); end
        else drv0 = fb[b];
        @(negedge clk);
      end
    if (which != 0) begin drv1 = 1'b1; rx_rd1 = 1'b0; end
    else drv0 = 1'b1;
  endtask

  task automatic decode1(output logic [6:0] d, output logic p, output logic [1:0] st, output bit ok);
    int n;
    n = 0; ok = 1'b1; d = '0; p = 1'b0; st = '0;
    while (txd1 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin ok = 1'b0; return; end
    repeat (DIV1 / 2) @(negedge clk);
    for (int i = 0; i < 7; i++) begin repeat (DIV1) @(negedge clk); d[i] = txd1; end
    repeat (DIV1) @(negedge clk); p = txd1;
    repeat (DIV1) @(negedge clk); st[0] = txd1;
    repeat (DIV1) @(negedge clk); st[1] = txd1;
  endtask

  task automatic pop0();
    rx_rd0 = 1'b1; @(negedge clk); rx_rd0 = 1'b0;
  endtask

  task automatic pop1();
    rx_rd1 = 1'b1; @(negedge clk); rx_rd1 = 1'b0;
  endtask

  task automatic test_reset_values();
    n_checks++;
    if ({txd0, tx_busy0, tx_full0, tx_empty0} !== 4'b1001) begin
      n_fail++; $display("FAIL reset_tx0: got %b expected 1001", {txd0, tx_busy0, tx_full0, tx_empty0});
    end
    n_checks++;
    if ({rx_empty0, rx_count0, rx_data0, pe0, fe0, ov0} !== {1'b1, 5'd0, 8'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_rx0: empty=%b count=%0d data=%h flags=%b expected 1/0/00/000",
                         rx_empty0, rx_count0, rx_data0, {pe0, fe0, ov0});
    end
    n_checks++;
    if ({txd1, tx_busy1, tx_empty1, rx_empty1, rx_count1, pe1, fe1, ov1} !== {4'b1011, 3'd0, 3'b000}) begin
      n_fail++; $display("FAIL reset_u1: got %b expected 1011000000",
                         {txd1, tx_busy1, tx_empty1, rx_empty1, rx_count1, pe1, fe1, ov1});
    end
  endtask

  task automatic test_tx_8n1();
    logic [7:0] v;
    int idx, b, first_bad, busy_hi;
    logic exp_txd;
    for (int f = 0; f < 3; f++) begin
      v = (f == 0) ? 8'h55 : 8'($urandom);
      tx_data0 = v; tx_wr0 = 1'b1; @(negedge clk); tx_wr0 = 1'b0;
      first_bad = -1; busy_hi = 0;
      for (int k = 1; k <= 920; k++) begin
        idx = k - 3;
        exp_txd = 1'b1;
        if (idx >= 0 && idx < 10 * DIV0) begin
          b = idx / DIV0;
          exp_txd = (b == 0) ? 1'b0 : (b <= 8) ? v[b-1] : 1'b1;
        end
        if (txd0 !== exp_txd && first_bad < 0) first_bad = k;
        if (tx_busy0 === 1'b1) busy_hi++;
        @(negedge clk);
      end
      n_checks++;
      if (first_bad >= 0) begin
        n_fail++; $display("FAIL tx_wave: data %h first wrong txd at cycle %0d, expected no deviation", v, first_bad);
      end
      n_checks++;
      if (busy_hi != 10 * DIV0) begin
        n_fail++; $display("FAIL tx_busy_len: got %0d cycles expected %0d", busy_hi, 10 * DIV0);
      end
    end
  endtask

  task automatic test_loopback();
    logic [7:0] exp[$];
    int n;
    lb0 = 1'b1;
    exp = '{8'hA5, 8'h3C, 8'hFF};
    for (int i = 0; i < 4; i++) exp.push_back(8'($urandom));
    foreach (exp[i]) begin tx_data0 = exp[i]; tx_wr0 = 1'b1; @(negedge clk); end
    tx_wr0 = 1'b0;
    n = 0;
    while (int'(rx_count0) != exp.size() && n < 9000) begin @(negedge clk); n++; end
    n_checks++;
    if (int'(rx_count0) != exp.size()) begin
      n_fail++; $display("FAIL loop_count: got %0d expected %0d", rx_count0, exp.size());
    end
    foreach (exp[i]) begin
      n_checks++;
      if (rx_data0 !== exp[i]) begin
        n_fail++; $display("FAIL loop_data[%0d]: got %h expected %h", i, rx_data0, exp[i]);
      end
      pop0();
    end
    pop0();
    n_checks++;
    if ({rx_empty0, rx_count0, pe0, fe0, ov0} !== {1'b1, 5'd0, 3'b000}) begin
      n_fail++; $display("FAIL loop_end: empty=%b count=%0d flags=%b expected 1/0/000",
                         rx_empty0, rx_count0, {pe0, fe0, ov0});
    end
    repeat (100) @(negedge clk);
  endtask

  task automatic test_reset();
    int n, lows, cnt_bad;
    lb0 = 1'b1;
    tx_data0 = 8'h12; tx_wr0 = 1'b1; @(negedge clk);
    tx_data0 = 8'h34; @(negedge clk);
    tx_data0 = 8'h56; @(negedge clk);
    tx_wr0 = 1'b0;
    n = 0;
    while (rx_count0 !== 5'd1 && n < 3000) begin @(negedge clk); n++; end
    n_checks++;
    if (rx_count0 !== 5'd1) begin
      n_fail++; $display("FAIL rst_prefill: got count %0d expected 1", rx_count0);
    end
    repeat (300) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    test_reset_values();
    rst = 1'b1;
    lows = 0; cnt_bad = 0;
    for (int k = 0; k < 2000; k++) begin
      if (txd0 !== 1'b1) lows++;
      if (rx_count0 !== 5'd0) cnt_bad++;
      @(negedge clk);
    end
    n_checks++;
    if (lows != 0 || cnt_bad != 0 || tx_empty0 !== 1'b1) begin
      n_fail++; $display("FAIL rst_quiet: txd low %0d cycles, count nonzero %0d cycles, tx_empty=%b expected 0/0/1",
                         lows, cnt_bad, tx_empty0);
    end
  endtask

  task automatic test_parity();
    logic [6:0] v, d, g;
    logic p;
    logic [1:0] st;
    bit ok;
    for (int f = 0; f < 4; f++) begin
      v = (f == 0) ? 7'h07 : 7'($urandom);
      tx_data1 = v; tx_wr1 = 1'b1; @(negedge clk); tx_wr1 = 1'b0;
      decode1(d, p, st, ok);
      n_checks++;
      if (!ok || d !== v || p !== (^v) || st !== 2'b11) begin
        n_fail++; $display("FAIL par_tx: ok=%0d data=%h par=%b stop=%b expected 1/%h/%b/11", ok, d, p, st, v, ^v);
      end
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if ({tx_busy1, tx_empty1} !== 2'b01) begin
      n_fail++; $display("FAIL par_tx_idle: busy/empty=%b expected 01", {tx_busy1, tx_empty1});
    end
    g = 7'($urandom);
    send_frame(1, {1'b0, g}, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_count1 !== 3'd1 || rx_data1 !== g || pe1 !== 1'b0) begin
      n_fail++; $display("FAIL par_rx_good: count=%0d data=%h perr=%b expected 1/%h/0", rx_count1, rx_data1, pe1, g);
    end
    send_frame(1, {1'b0, 7'($urandom)}, 1'b1, 1'b1, -1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (pe1 !== 1'b1 || rx_count1 !== 3'd1) begin
      n_fail++; $display("FAIL par_rx_bad: perr=%b count=%0d expected 1/1", pe1, rx_count1);
    end
    err_clr1 = 1'b1; @(negedge clk); err_clr1 = 1'b0;
    n_checks++;
    if (pe1 !== 1'b0) begin
      n_fail++; $display("FAIL par_clr: perr=%b expected 0", pe1);
    end
    pop1();
  endtask

  task automatic test_overrun();
    logic [6:0] c[5];
    logic [6:0] t[6];
    logic [6:0] got[5];
    logic p;
    logic [1:0] st;
    bit oks[5];
    logic full_before, full_after;
    int lows;
    for (int i = 0; i < 5; i++) c[i] = 7'($urandom);
    for (int i = 0; i < 5; i++) send_frame(1, {1'b0, c[i]}, 1'b0, 1'b1, -1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_count1 !== 3'd4 || ov1 !== 1'b1) begin
      n_fail++; $display("FAIL ovr_set: count=%0d ovr=%b expected 4/1", rx_count1, ov1);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_data1 !== c[i]) begin
        n_fail++; $display("FAIL ovr_data[%0d]: got %h expected %h", i, rx_data1, c[i]);
      end
      pop1();
    end
    err_clr1 = 1'b1; @(negedge clk); err_clr1 = 1'b0;
    n_checks++;
    if (ov1 !== 1'b0 || rx_empty1 !== 1'b1) begin
      n_fail++; $display("FAIL ovr_clr: ovr=%b empty=%b expected 0/1", ov1, rx_empty1);
    end
    // stop sample lands 3 clocks of sync/edge latency + div/2 + 9*div after the start edge
    for (int i = 0; i < 5; i++) c[i] = 7'($urandom);
    for (int i = 0; i < 5; i++) send_frame(1, {1'b0, c[i]}, 1'b0, 1'b1, (i == 4) ? (2 + DIV1 / 2 + 9 * DIV1) : -1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (rx_count1 !== 3'd4 || ov1 !== 1'b0) begin
      n_fail++; $display("FAIL ovr_popsame: count=%0d ovr=%b expected 4/0", rx_count1, ov1);
    end
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (rx_data1 !== c[i]) begin
        n_fail++; $display("FAIL ovr_popsame_data[%0d]: got %h expected %h", i, rx_data1, c[i]);
      end
      pop1();
    end
    for (int i = 0; i < 6; i++) t[i] = 7'($urandom);
    full_before = 1'b0; full_after = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 5) full_before = tx_full1;
          tx_data1 = t[i]; tx_wr1 = 1'b1; @(negedge clk);
        end
        tx_wr1 = 1'b0;
        full_after = tx_full1;
      end
      begin
        for (int i = 0; i < 5; i++) decode1(got[i], p, st, oks[i]);
      end
    join
    n_checks++;
    if (full_before !== 1'b1 || full_after !== 1'b1) begin
      n_fail++; $display("FAIL txfull_flag: before=%b after=%b expected 1/1", full_before, full_after);
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (!oks[i] || got[i] !== t[i]) begin
        n_fail++; $display("FAIL txfull_data[%0d]: ok=%0d got %h expected %h", i, oks[i], got[i], t[i]);
      end
    end
    lows = 0;
    for (int k = 0; k < 300; k++) begin if (txd1 !== 1'b1) lows++; @(negedge clk); end
    n_checks++;
    if (lows != 0 || tx_empty1 !== 1'b1) begin
      n_fail++; $display("FAIL txfull_ignored: extra low cycles %0d tx_empty=%b expected 0/1", lows, tx_empty1);
    end
  endtask

  task automatic test_line_faults();
    lb0 = 1'b0; drv0 = 1'b1;
    repeat (20) @(negedge clk);
    drv0 = 1'b0; repeat (20) @(negedge clk); drv0 = 1'b1;
    repeat (300) @(negedge clk);
    n_checks++;
    if (rx_count0 !== 5'd0 || {pe0, fe0, ov0} !== 3'b000) begin
      n_fail++; $display("FAIL glitch: count=%0d flags=%b expected 0/000", rx_count0, {pe0, fe0, ov0});
    end
    send_frame(0, 8'($urandom), 1'b0, 1'b0, -1);
    repeat (10) @(negedge clk);
    n_checks++;
    if (fe0 !== 1'b1 || rx_count0 !== 5'd0) begin
      n_fail++; $display("FAIL frame_err: ferr=%b count=%0d expected 1/0", fe0, rx_count0);
    end
    err_clr0 = 1'b1; @(negedge clk); err_clr0 = 1'b0;
    n_checks++;
    if (fe0 !== 1'b0) begin
      n_fail++; $display("FAIL frame_clr: ferr=%b expected 0", fe0);
    end
    drv0 = 1'b0; repeat (2000) @(negedge clk);
    drv0 = 1'b1; repeat (200) @(negedge clk);
    send_frame(0, 8'h81, 1'b0, 1'b1, -1);
    repeat (10) @(negedge clk);
    n_checks++;
    if (rx_count0 !== 5'd1 || rx_data0 !== 8'h81 || fe0 !== 1'b1) begin
      n_fail++; $display("FAIL long_low: count=%0d data=%h ferr=%b expected 1/81/1", rx_count0, rx_data0, fe0);
    end
    err_clr0 = 1'b1; pop0(); err_clr0 = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    tx_data0 = '0; tx_wr0 = 1'b0; rx_rd0 = 1'b0; err_clr0 = 1'b0; drv0 = 1'b1; lb0 = 1'b0;
    tx_data1 = '0; tx_wr1 = 1'b0; rx_rd1 = 1'b0; err_clr1 = 1'b0; drv1 = 1'b1;
    repeat (3) @(negedge clk);
    test_reset_values();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    test_tx_8n1();
    test_loopback();
    test_reset();
    test_parity();
    test_overrun();
    test_line_faults();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
